mips32_program_loader: RTL and testbench
========================================

Name: mips32_program_loader

Overview:
- Hardware replacement for the bench-side memory preload of the single-cycle MIPS core.
- Accepts a word stream over a valid/ready handshake and writes it into the register file and then the instruction memory.
- Holds the core stalled until the load completes, then releases it through cpu_run.
- Sits between a host/UART front end and the core's INST_MEMORY and registers write ports.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction memory words.
- IMEM_AW, 8, instruction address width (clog2 of IMEM_DEPTH).
- NUM_REGS, 32, register file entries loaded; fixed 5-bit address.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  restarts a load from DONE or ERROR; ignored in other states.
- in_valid  in  1  host word valid.
- in_data  in  32  host word.
- in_ready  out  1  loader accepts in_data when in_valid and in_ready are both high.
- rf_we  out  1  register file write enable.
- rf_addr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- imem_we  out  1  instruction memory write enable.
- imem_addr  out  IMEM_AW  instruction memory word address.
- imem_wdata  out  32  instruction word.
- cpu_run  out  1  high allows the core to execute; low stalls it.
- error  out  1  sticky header error flag.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=HEADER; in_ready=1; rf_we=0, imem_we=0; rf_addr=0, imem_addr=0; rf_wdata=0, imem_wdata=0; cpu_run=0; error=0; counters=0.
- A reset asserted mid-load aborts the load. No partial-write flag is kept, and the host must resend the load from the header.
- Handshake:
  - A transfer occurs only on the clk edge where in_valid && in_ready.
  - in_data is sampled only on that edge.
  - in_ready is a function of state only. It is never combinationally dependent on in_valid.
- State HEADER:
  - On transfer, N = in_data[15:0] (instruction count); the remaining header bits are ignored.
  - If N==0 or N>IMEM_DEPTH, go to ERROR. Otherwise latch N, clear reg_cnt, and go to LOAD_REGS.
- State LOAD_REGS:
  - Each transfer registers rf_we=1, rf_addr=reg_cnt, rf_wdata=in_data for exactly the next cycle, then increments reg_cnt. Latency is 1 cycle from handshake to write strobe.
  - After transfer NUM_REGS-1 (reg_cnt==31), clear inst_cnt and go to LOAD_INST.
  - Register 0 is written like any other entry; masking it is the register file's job.
- State LOAD_INST:
  - Each transfer registers imem_we=1, imem_addr=inst_cnt, imem_wdata=in_data for the next cycle, then increments inst_cnt.
  - On transfer N-1, go to DONE.
  - inst_cnt never wraps, because N<=IMEM_DEPTH is enforced in HEADER.
- State DONE:
  - in_ready=0.
  - cpu_run=1, first asserted the cycle after the final imem_we pulse. The last write therefore lands before the core fetches.
  - start=1 sets cpu_run=0, in_ready=1, and goes to HEADER.
- State ERROR:
  - in_ready=0, error=1, cpu_run=0.
  - start clears error and goes to HEADER.
- Idle cycles (in_valid=0) in any load state change nothing; write enables stay 0. Gaps of any length are legal.
- rf_we and imem_we are never high in the same cycle. Each is high only in the cycle after an accepted word.
- start outside DONE/ERROR is ignored, and so is start held together with reset (reset wins).

Decomposition:
- Package mips32_loader_pkg:
  - state enum {HEADER, LOAD_REGS, LOAD_INST, DONE, ERROR};
  - NUM_REGS;
  - REG_AW=5;
  - header field position constant HDR_N_MSB=15.
- No sub-module is needed. The FSM, the two counters and the registered write ports fit in one module of about 150–200 lines.

Test Plan:
- Reset, then N=3, regs 0..31 = i*0x11, instructions 0x20080005, 0x20090007, 0x01095020 with in_valid held high:
  - exactly 32 rf_we pulses, addr 0..31, data = i*0x11;
  - then 3 imem_we pulses at addr 0..2 with those words;
  - cpu_run rises the cycle after the last pulse and in_ready drops.
- Same load with in_valid toggled 1/0 randomly → identical write sequence. No write occurs in any cycle following in_valid=0.
- Header N=0, then N=IMEM_DEPTH+1 (257) → error=1, in_ready=0, no writes. start → error=0, in_ready=1, state HEADER.
- Header N=256 → 256 imem writes, last at imem_addr=255. No wrap; cpu_run=1.
- reset asserted after 10 register words → all outputs return to reset values next cycle. A full reload then completes normally starting at rf_addr=0.
- In DONE, start=1 → cpu_run=0 next cycle. A new load of N=1 writes imem_addr=0 only, then cpu_run=1.

Source files
------------

// File: rtl/mips32_loader_pkg.sv
// Shared types and constants for the MIPS32 program loader.
// Header word layout: bits [HDR_N_MSB:0] carry the instruction count.
package mips32_loader_pkg;

   localparam int NUM_REGS  = 32;
   localparam int REG_AW    = 5;
   localparam int HDR_N_MSB = 15;

   typedef enum logic [2:0] {
      HEADER,
      LOAD_REGS,
      LOAD_INST,
      DONE,
      ERROR
   } state_t;

endpackage

// File: rtl/mips32_program_loader.sv
// Streams a header, 32 register words and N instruction words into the core's
// register file and instruction memory, holding the core stalled until done.
module mips32_program_loader #(
   parameter int IMEM_DEPTH = 256,
   parameter int IMEM_AW    = 8,
   parameter int NUM_REGS   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               in_valid,
   input  logic [31:0]        in_data,
   output logic               in_ready,
   output logic               rf_we,
   output logic [4:0]         rf_addr,
   output logic [31:0]        rf_wdata,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic [31:0]        imem_wdata,
   output logic               cpu_run,
   output logic               error
);

   import mips32_loader_pkg::*;

   state_t              state;
   logic [REG_AW-1:0]   reg_cnt;
   logic [IMEM_AW-1:0]  inst_cnt;
   logic [IMEM_AW-1:0]  n_last;
   logic [HDR_N_MSB:0]  hdr_n;
   logic                hdr_bad;
   logic                fire;

   assign fire    = in_valid && in_ready;
   assign hdr_n   = in_data[HDR_N_MSB:0];
   assign hdr_bad = (hdr_n == '0) || (32'(hdr_n) > 32'(IMEM_DEPTH));

   // in_ready is registered alongside every state change, so it never sees in_valid
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= HEADER;
         in_ready   <= 1'b1;
         rf_we      <= 1'b0;
         rf_addr    <= '0;
         rf_wdata   <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         cpu_run    <= 1'b0;
         error      <= 1'b0;
         reg_cnt    <= '0;
         inst_cnt   <= '0;
         n_last     <= '0;
      end else begin
         rf_we   <= 1'b0;
         imem_we <= 1'b0;
         case (state)
            HEADER: begin
               if (fire) begin
                  if (hdr_bad) begin
                     state    <= ERROR;
                     error    <= 1'b1;
                     in_ready <= 1'b0;
                  end else begin
                     n_last  <= IMEM_AW'(hdr_n - 16'd1);
                     reg_cnt <= '0;
                     state   <= LOAD_REGS;
                  end
               end
            end
            LOAD_REGS: begin
               if (fire) begin
                  rf_we    <= 1'b1;
                  rf_addr  <= reg_cnt;
                  rf_wdata <= in_data;
                  reg_cnt  <= reg_cnt + REG_AW'(1);
                  if (reg_cnt == REG_AW'(NUM_REGS - 1)) begin
                     inst_cnt <= '0;
                     state    <= LOAD_INST;
                  end
               end
            end
            LOAD_INST: begin
               if (fire) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= inst_cnt;
                  imem_wdata <= in_data;
                  // Counter holds on the last word so a full-depth load never wraps
                  if (inst_cnt == n_last) begin
                     state    <= DONE;
                     in_ready <= 1'b0;
                  end else begin
                     inst_cnt <= inst_cnt + IMEM_AW'(1);
                  end
               end
            end
            DONE: begin
               if (start) begin
                  cpu_run  <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= HEADER;
               end else begin
                  cpu_run <= 1'b1;
               end
            end
            ERROR: begin
               if (start) begin
                  error    <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= HEADER;
               end
            end
            default: begin
               state    <= HEADER;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mips32_program_loader.sv
// Scoreboard bench for mips32_program_loader: stimulus pushes expected writes,
// a negedge monitor pops and compares every write strobe.
module tb_mips32_program_loader;

   localparam int IMEM_DEPTH = 256;
   localparam int IMEM_AW    = 8;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               start = 1'b0;
   logic               in_valid = 1'b0;
   logic [31:0]        in_data = '0;
   logic               in_ready;
   logic               rf_we;
   logic [4:0]         rf_addr;
   logic [31:0]        rf_wdata;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [31:0]        imem_wdata;
   logic               cpu_run;
   logic               error;

   mips32_program_loader #(
      .IMEM_DEPTH (IMEM_DEPTH),
      .IMEM_AW    (IMEM_AW),
      .NUM_REGS   (32)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .rf_we      (rf_we),
      .rf_addr    (rf_addr),
      .rf_wdata   (rf_wdata),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_imem;
      int unsigned addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] prog[IMEM_DEPTH];
   logic        fire_q = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every strobe must follow an accepted word and match the queue head
   always @(posedge clk) fire_q <= !reset && in_valid && in_ready;

   always @(negedge clk) begin
      wr_t e;
      if (rf_we && imem_we) chk("both_we", 32'd1, 32'd0);
      if ((rf_we || imem_we) && !fire_q) chk("we_without_xfer", 32'd1, 32'd0);
      if (rf_we || imem_we) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {31'd0, imem_we}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_kind", {31'd0, imem_we}, {31'd0, e.is_imem});
            if (e.is_imem) begin
               chk("imem_addr", 32'(imem_addr), e.addr);
               chk("imem_wdata", imem_wdata, e.data);
            end else begin
               chk("rf_addr", 32'(rf_addr), e.addr);
               chk("rf_wdata", rf_wdata, e.data);
            end
         end
      end
   end

   // Inputs change at posedge+1; in_ready seen then is what the next edge samples
   task automatic send(input logic [31:0] d, input bit toggle);
      int t = 0;
      if (toggle && $urandom_range(1) == 1) begin
         in_valid = 1'b0;
         repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
      end
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
      if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      if (toggle) in_valid = 1'b0;
   endtask

   task automatic push_wr(input bit im, input int unsigned a, input logic [31:0] d);
      wr_t e;
      e.is_imem = im; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic do_load(input int n, input bit toggle);
      send(32'(n) | 32'hABCD_0000, toggle);
      for (int i = 0; i < 32; i++) begin
         send(32'(i) * 32'h11, toggle);
         push_wr(1'b0, i, 32'(i) * 32'h11);
      end
      for (int j = 0; j < n; j++) begin
         chk("run_low_during_load", {31'd0, cpu_run}, 32'd0);
         send(prog[j], toggle);
         push_wr(1'b1, j, prog[j]);
      end
      in_valid = 1'b0;
      chk("last_pulse_run_low", {31'd0, cpu_run}, 32'd0);
      chk("done_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
      chk("cpu_run_rise", {31'd0, cpu_run}, 32'd1);
      chk("done_in_ready_hold", {31'd0, in_ready}, 32'd0);
      chk("queue_drained", exp_q.size(), 32'd0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_rf_we"}, {31'd0, rf_we}, 32'd0);
      chk({tag, "_imem_we"}, {31'd0, imem_we}, 32'd0);
      chk({tag, "_rf_addr"}, 32'(rf_addr), 32'd0);
      chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
      chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
      chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
      chk({tag, "_cpu_run"}, {31'd0, cpu_run}, 32'd0);
      chk({tag, "_error"}, {31'd0, error}, 32'd0);
   endtask

   task automatic bad_header(input logic [31:0] hdr, input string tag);
      send(hdr, 1'b0);
      in_valid = 1'b0;
      chk({tag, "_error"}, {31'd0, error}, 32'd1);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
      repeat (3) begin @(posedge clk); #1; end
      chk({tag, "_run"}, {31'd0, cpu_run}, 32'd0);
      pulse_start();
      chk({tag, "_clr_error"}, {31'd0, error}, 32'd0);
      chk({tag, "_clr_in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h2009_0007;
      prog[2] = 32'h0109_5020;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk_reset_values("rst");

      // Basic load, in_valid held high
      do_load(3, 1'b0);
      pulse_start();
      chk("start_run_low", {31'd0, cpu_run}, 32'd0);

      // Same load with random idle gaps
      do_load(3, 1'b1);
      pulse_start();

      // Header errors
      bad_header(32'h0000_0000, "n0");
      bad_header(32'hFFFF_0000 | 32'(IMEM_DEPTH + 1), "n257");

      // Start in HEADER is ignored, then full-depth load
      pulse_start();
      chk("start_ignored_ready", {31'd0, in_ready}, 32'd1);
      for (int j = 0; j < IMEM_DEPTH; j++) prog[j] = (32'(j) * 32'h0101_0101) ^ 32'hA5A5_0000;
      do_load(IMEM_DEPTH, 1'b0);

      // Restart from DONE with N=1
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("restart_run_low", {31'd0, cpu_run}, 32'd0);
      chk("restart_ready", {31'd0, in_ready}, 32'd1);
      prog[0] = 32'hDEAD_BEEF;
      do_load(1, 1'b0);
      pulse_start();

      // Reset mid-load after ten register words
      send(32'd3, 1'b0);
      for (int i = 0; i < 10; i++) begin
         send(32'(i) * 32'h11, 1'b0);
         push_wr(1'b0, i, 32'(i) * 32'h11);
      end
      reset = 1'b1; start = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      chk_reset_values("midrst");
      chk("midrst_queue", exp_q.size(), 32'd0);
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h2009_0007;
      prog[2] = 32'h0109_5020;
      do_load(3, 1'b1);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
